// File: rtl/mpadd_serial.sv
// mpadd_serial: word-serial multi-precision adder/subtractor with registered result stream
module mpadd_serial #(
  parameter int WIDTH  = 32,
  parameter int NWORDS = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub_nadd,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int CNT_W = $clog2(NWORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             zacc_q, zacc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_zero_q, out_zero_d;
  logic             acc, first, last, sub_eff, cin, dz, zall;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  assign in_ready  = !out_valid_q | out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;
  // one word of the chained add, plus next-state for index, carry, flags and output register
  always_comb begin
    acc         = in_valid & in_ready;
    first       = idx_q == '0;
    last        = idx_q == LAST_IDX;
    sub_eff     = first ? in_sub_nadd : sub_q;
    cin         = first ? in_sub_nadd : carry_q;
    b_eff       = sub_eff ? ~in_b : in_b;
    sum         = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    dz          = sum[WIDTH-1:0] == '0;
    zall        = (first | zacc_q) & dz;
    idx_d       = acc ? (last ? '0 : idx_q + CNT_W'(1)) : idx_q;
    carry_d     = acc ? sum[WIDTH] : carry_q;
    sub_d       = acc & first ? in_sub_nadd : sub_q;
    zacc_d      = acc ? (!last & zall) : zacc_q;
    out_valid_d = acc | (out_valid_q & !out_ready);
    out_data_d  = acc ? sum[WIDTH-1:0] : out_data_q;
    out_last_d  = acc ? last : out_last_q;
    out_cout_d  = acc ? last & sum[WIDTH] : out_cout_q;
    out_ovf_d   = acc ? last & (in_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != in_a[WIDTH-1]) : out_ovf_q;
    out_zero_d  = acc ? last & zall : out_zero_q;
  end
  // state and output register with synchronous reset
  always_ff @(posedge clk) begin
    if (srst) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      zacc_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      zacc_q      <= zacc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_zero_q  <= out_zero_d;
    end
  end
endmodule

// File: tb/tb_mpadd_serial.sv
// tb_mpadd_serial: directed and random checks of mpadd_serial against a full-width arithmetic model
module tb_mpadd_serial;
  localparam int W    = 8;
  localparam int NW   = 2;
  localparam int TOT  = W * NW;
  localparam int MASK = (1 << TOT) - 1;
  localparam int HALF = 1 << (TOT - 1);
  typedef struct packed {logic [W-1:0] d; logic l, c, o, z;} exp_t;
  typedef struct packed {logic [W-1:0] a, b; logic s;} in_t;
  logic clk = 0, srst = 1, in_valid = 0, in_ready, in_sub_nadd = 0, out_valid, out_ready = 0;
  logic out_last, out_cout, out_ovf, out_zero;
  logic [W-1:0] in_a = 0, in_b = 0, out_data;
  int n_assert = 0, n_fail = 0;
  exp_t eq[$];
  in_t iq[$];
  mpadd_serial #(.WIDTH(W), .NWORDS(NW)) dut (
    .clk(clk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready), .in_sub_nadd(in_sub_nadd),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_op(input int a, input int b, input bit sub);
    int r, sa, sb, sr;
    bit c, o;
    in_t x;
    exp_t e;
    a &= MASK;
    b &= MASK;
    r = sub ? a - b : a + b;
    c = sub ? (a >= b) : (r > MASK);
    r &= MASK;
    sa = a >= HALF ? a - (1 << TOT) : a;
    sb = b >= HALF ? b - (1 << TOT) : b;
    sr = sub ? sa - sb : sa + sb;
    o = (sr >= HALF) || (sr < -HALF);
    for (int k = 0; k < NW; k++) begin
      x.a = W'(a >> (W * k));
      x.b = W'(b >> (W * k));
      x.s = (k == 0) ? sub : 1'($urandom_range(0, 1));
      iq.push_back(x);
      e.d = W'(r >> (W * k));
      e.l = k == NW - 1;
      e.c = e.l & c;
      e.o = e.l & o;
      e.z = e.l & (r == 0);
      eq.push_back(e);
    end
  endtask
  task automatic run(input int mode);
    int cyc = 0, n;
    bit stalled = 0, acc;
    logic [W-1:0] held = 0;
    exp_t e;
    n = iq.size();
    while ((iq.size() > 0 || eq.size() > 0) && cyc < 500) begin
      in_valid = iq.size() > 0;
      in_a = in_valid ? iq[0].a : '0;
      in_b = in_valid ? iq[0].b : '0;
      in_sub_nadd = in_valid ? iq[0].s : 1'b0;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : !(cyc >= 2 && cyc < 5);
      #1;
      if (stalled) chk("hold_data", 32'(out_data), 32'(held));
      stalled = out_valid && !out_ready;
      if (stalled) begin
        chk("stall_ready", 32'(in_ready), 32'd0);
        held = out_data;
      end
      if (out_valid && out_ready) begin
        if (eq.size() == 0) chk("extra_word", 32'd1, 32'd0);
        else begin
          e = eq.pop_front();
          chk("data", 32'(out_data), 32'(e.d));
          chk("last", 32'(out_last), 32'(e.l));
          chk("cout", 32'(out_cout), 32'(e.c));
          chk("ovf", 32'(out_ovf), 32'(e.o));
          chk("zero", 32'(out_zero), 32'(e.z));
        end
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) void'(iq.pop_front());
      cyc++;
    end
    chk("timeout", 32'(cyc < 500), 32'd1);
    if (mode == 0) chk("throughput_cycles", 32'(cyc), 32'(n + 1));
    in_valid = 0;
    out_ready = 1;
    iq.delete();
    eq.delete();
  endtask
  task automatic chk_reset_outputs();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_cout", 32'(out_cout), 0);
    chk("rst_ovf", 32'(out_ovf), 0);
    chk("rst_zero", 32'(out_zero), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    srst = 0;
    push_op(16'h01FF, 16'h0001, 0);
    run(0);
    push_op(16'h0000, 16'h0001, 1);
    run(0);
    push_op(16'h7FFF, 16'h0001, 0);
    run(0);
    push_op(16'h1234, 16'h1234, 1);
    run(0);
    push_op(16'h8000, 16'h0001, 1);
    push_op(16'hFFFF, 16'hFFFF, 0);
    run(2);
    push_op(16'hFFFF, 16'h0001, 0);
    push_op(16'h0003, 16'h0005, 1);
    run(0);
    in_valid = 1;
    in_a = 8'h11;
    in_b = 8'h22;
    in_sub_nadd = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    srst = 1;
    @(posedge clk);
    #1;
    chk_reset_outputs();
    srst = 0;
    push_op(16'h0005, 16'h0003, 1);
    run(0);
    for (int i = 0; i < 20; i++) push_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 1'($urandom_range(0, 1)));
    run(1);
    for (int i = 0; i < 6; i++) push_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 1'($urandom_range(0, 1)));
    run(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
